// File: rtl/sha256_round_engine_if.sv
// Block-in / digest-out handshake bundle for the SHA-256 round engine.
interface sha256_round_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic         in_first;
   logic [511:0] in_block;
   logic         out_valid;
   logic [255:0] out_digest;
   logic         busy;

   modport master (
      output in_valid, in_first, in_block,
      input  in_ready, out_valid, out_digest, busy
   );

   modport slave (
      input  in_valid, in_first, in_block,
      output in_ready, out_valid, out_digest, busy
   );
endinterface

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression: one round per cycle over a rolling 16-word schedule,
// with the round-constant table in k_constants and block chaining through out_digest.
module k_constants (
   input  logic [5:0]  round,
   output logic [31:0] k
);
   // Round-constant lookup indexed by the round counter
   always_comb begin
      k = 32'h0000_0000;
      case (round)
         6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
         6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
         6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
         6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
         6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
         6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
         6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
         6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
         6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
         6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
         6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
         6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
         6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
         6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
         6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
         6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
         6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
         6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
         6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
         6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
         6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
         6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
         6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
         6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
         6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
         6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
         6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
         6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
         6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
         6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
         6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
         6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
         default: k = 32'h0000_0000;
      endcase
   end
endmodule

module sha256_round_engine #(
   parameter logic [255:0] INIT_H = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
   input  logic                  clk,
   input  logic                  rst,
   sha256_round_engine_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ROUNDS = 2'd1, FINAL = 2'd2} state_t;

   state_t       state, next_state;
   logic [5:0]   round;
   logic [31:0]  a, b, c, d, e, f, g, h;
   logic [31:0]  w [16];
   logic [255:0] base;
   logic [255:0] digest;
   logic         valid_pulse;
   logic [31:0]  k;
   logic [31:0]  t1, t2, w_next;
   logic [255:0] start_h;

   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] small_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] small_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
   endfunction

   k_constants u_k (.round(round), .k(k));

   assign bus.in_ready   = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.out_valid  = valid_pulse;
   assign bus.out_digest = digest;

   // Round arithmetic and next schedule word
   always_comb begin
      t1      = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w[0];
      t2      = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
      w_next  = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
      start_h = bus.in_first ? INIT_H : digest;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state decode
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.in_valid) next_state = ROUNDS; else next_state = IDLE;
         ROUNDS:  if (round == 6'd63) next_state = FINAL; else next_state = ROUNDS;
         FINAL:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Working variables, schedule window, chaining base and digest
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round       <= 6'd0;
         {a, b, c, d, e, f, g, h} <= 256'h0;
         for (int i = 0; i < 16; i++) w[i] <= 32'h0;
         base        <= INIT_H;
         digest      <= INIT_H;
         valid_pulse <= 1'b0;
      end else begin
         valid_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  {a, b, c, d, e, f, g, h} <= start_h;
                  base  <= start_h;
                  round <= 6'd0;
                  for (int i = 0; i < 16; i++) w[i] <= bus.in_block[511 - 32*i -: 32];
               end else begin
                  round <= round;
               end
            end
            ROUNDS: begin
               h <= g; g <= f; f <= e; e <= d + t1;
               d <= c; c <= b; b <= a; a <= t1 + t2;
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_next;
               round <= round + 6'd1;
            end
            FINAL: begin
               // Feed-forward add of the block's starting hash value
               digest <= {base[255:224] + a, base[223:192] + b, base[191:160] + c, base[159:128] + d,
                          base[127:96]  + e, base[95:64]    + f, base[63:32]    + g, base[31:0]     + h};
               valid_pulse <= 1'b1;
            end
            default: round <= 6'd0;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_round_engine.sv
// Randomized and known-vector bench for sha256_round_engine against a plain SHA-256 model.
module tb_sha256_round_engine;
   localparam logic [255:0] INIT_H = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC_D  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_D  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [511:0] ABC_B  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_B2 = {448'h0, 64'h1c0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [255:0] exp_hash;
   logic [255:0] dig;

   logic [31:0] kt [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   sha256_round_engine_if bus ();

   sha256_round_engine #(.INIT_H(INIT_H)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 compression with a fully expanded 64-word schedule
   function automatic logic [255:0] sha_ref(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] x1, x2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
         x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + x1;
         v[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the engine idle; returns at the negedge where out_valid is seen
   task automatic run_block(input string tag, input logic first, input logic [511:0] blk,
                            input bit hold, output logic [255:0] d);
      int k;
      bit got;
      logic [255:0] pre;
      pre = bus.out_digest;
      check_eq({tag, "_ready"}, {255'h0, bus.in_ready}, 256'h1);
      bus.in_valid = 1'b1;
      bus.in_first = first;
      bus.in_block = blk;
      @(posedge clk);
      k = -1;
      got = 1'b0;
      d = '0;
      while (!got && k < 200) begin
         @(negedge clk);
         k++;
         if (bus.out_valid) begin
            got = 1'b1;
            bus.in_valid = 1'b0;
         end else if (hold) begin
            bus.in_valid = 1'b1;
            bus.in_first = 1'($urandom_range(0, 1));
            bus.in_block = {16{$urandom()}};
         end else begin
            bus.in_valid = 1'b0;
         end
         if (k == 30) begin
            check_eq({tag, "_busy"}, {255'h0, bus.busy}, 256'h1);
            check_eq({tag, "_hold_digest"}, bus.out_digest, pre);
         end
      end
      if (!got) begin
         check_eq({tag, "_timeout"}, 256'h0, 256'h1);
      end else begin
         check_eq({tag, "_latency"}, 256'(k), 256'd65);
         check_eq({tag, "_ready_at_valid"}, {255'h0, bus.in_ready}, 256'h1);
         d = bus.out_digest;
      end
   endtask

   initial begin
      logic         fst;
      logic [511:0] rb;
      bit           seen;
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_block = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", {255'h0, bus.in_ready}, 256'h1);
      check_eq("rst_busy", {255'h0, bus.busy}, 256'h0);
      check_eq("rst_valid", {255'h0, bus.out_valid}, 256'h0);
      check_eq("rst_digest", bus.out_digest, INIT_H);
      rst = 1'b0;
      @(negedge clk);

      run_block("first0_abc", 1'b0, ABC_B, 1'b0, dig);
      check_eq("first0_abc", dig, ABC_D);
      @(negedge clk);
      check_eq("pulse_len", {255'h0, bus.out_valid}, 256'h0);
      check_eq("digest_held", bus.out_digest, ABC_D);

      run_block("empty", 1'b1, EMPTY_B, 1'b0, dig);
      check_eq("empty", dig, EMPTY_D);

      run_block("two_b1", 1'b1, TWO_B1, 1'b0, dig);
      run_block("two_b2", 1'b0, TWO_B2, 1'b0, dig);
      check_eq("two_block", dig, TWO_D);

      run_block("abc_after_chain", 1'b1, ABC_B, 1'b0, dig);
      check_eq("abc_after_chain", dig, ABC_D);

      run_block("hold_valid", 1'b1, EMPTY_B, 1'b1, dig);
      check_eq("hold_valid", dig, EMPTY_D);
      @(negedge clk);
      check_eq("hold_no_extra", {255'h0, bus.busy}, 256'h0);

      // Abort "abc" around round 30
      bus.in_valid = 1'b1;
      bus.in_first = 1'b1;
      bus.in_block = ABC_B;
      @(posedge clk);
      bus.in_valid = 1'b0;
      repeat (31) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_digest", bus.out_digest, INIT_H);
      check_eq("abort_ready", {255'h0, bus.in_ready}, 256'h1);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check_eq("abort_no_valid", {255'h0, seen}, 256'h0);
      run_block("abc_rerun", 1'b1, ABC_B, 1'b0, dig);
      check_eq("abc_rerun", dig, ABC_D);
      exp_hash = ABC_D;

      for (int n = 0; n < 6; n++) begin
         fst = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < 16; i++) rb[511 - 32*i -: 32] = $urandom();
         exp_hash = sha_ref(fst ? INIT_H : exp_hash, rb);
         run_block("rand", fst, rb, 1'b0, dig);
         check_eq("rand_digest", dig, exp_hash);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
